leb128_byte_window: RTL



---
 rtl/leb128_byte_window_pkg.sv | 9 +
 rtl/leb128_byte_window_byte_shift_right.sv | 10 +
 rtl/leb128_byte_window.sv | 97 +++++++++
 3 files changed

// File: rtl/leb128_byte_window_pkg.sv
// Constants shared by the LEB128 byte window, the immediate decoder and the fetch unit.
package leb128_byte_window_pkg;
  localparam int WIN_BYTES  = 5;
  localparam int BUF_BYTES  = 8;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  typedef logic [CNT_W-1:0] byte_cnt_t;
endpackage

// File: rtl/leb128_byte_window_byte_shift_right.sv
// Combinational right shift of a byte vector by 0..7 whole bytes, zero-filling from the top.
module byte_shift_right #(
  parameter int BYTES = 8
) (
  input  logic [8*BYTES-1:0] data,
  input  logic [2:0]         shift,
  output logic [8*BYTES-1:0] result
);
  assign result = data >> {shift, 3'b000};
endmodule

// File: rtl/leb128_byte_window.sv
// 8-byte shift buffer between 32-bit instruction words and the LEB128 decoder operand window.
module leb128_byte_window #(
  parameter int WORD_BYTES = 4,
  parameter int BUF_BYTES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*WORD_BYTES-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [39:0]             win_data,
  output logic [3:0]              win_count,
  input  logic                    consume,
  input  logic [2:0]              consume_cnt,
  input  logic                    flush,
  input  logic [1:0]              flush_skip,
  output logic                    err
);
  import leb128_byte_window_pkg::*;

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int BUF_W  = 8 * BUF_BYTES;

  logic [BUF_W-1:0] buf_p1;
  byte_cnt_t        count_p1;
  logic [1:0]       skip_pend_p1;
  logic             err_p1;

  logic             push;
  logic             cons_legal;
  logic [2:0]       c_cnt;
  logic [2:0]       p_cnt;
  byte_cnt_t        base;
  byte_cnt_t        count_next;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] aligned;
  logic [BUF_W-1:0] buf_next;

  assign in_ready   = (count_p1 <= byte_cnt_t'(4)) & ~flush;
  assign push       = in_valid & in_ready;
  assign cons_legal = consume && (consume_cnt != 3'd0) && (consume_cnt <= 3'(WIN_BYTES))
                      && ({1'b0, consume_cnt} <= count_p1);
  assign c_cnt      = cons_legal ? consume_cnt : 3'd0;
  assign p_cnt      = push ? (3'd4 - {1'b0, skip_pend_p1}) : 3'd0;
  assign base       = count_p1 - {1'b0, c_cnt};
  assign count_next = base + {1'b0, p_cnt};

  byte_shift_right #(.BYTES(BUF_BYTES)) u_consume_shift (
    .data   (buf_p1),
    .shift  (c_cnt),
    .result (shifted)
  );

  byte_shift_right #(.BYTES(BUF_BYTES)) u_skip_align (
    .data   ({{(BUF_W-DATA_W){1'b0}}, in_data}),
    .shift  ({1'b0, skip_pend_p1}),
    .result (aligned)
  );

  // Lanes at or above count-c take the aligned word; everything else keeps the shifted buffer,
  // whose vacated upper bytes are already zero.
  always_comb begin
    logic [3:0] off;
    buf_next = shifted;
    off      = 4'd0;
    for (int i = 0; i < BUF_BYTES; i++) begin
      off = 4'(i) - base;
      if (push && (4'(i) >= base) && (off < {1'b0, p_cnt}))
        buf_next[8*i +: 8] = aligned[{off[2:0], 3'b000} +: 8];
    end
  end

  // Stage p1: buffer state and the error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_p1       <= '0;
      count_p1     <= '0;
      skip_pend_p1 <= '0;
      err_p1       <= 1'b0;
    end else if (flush) begin
      buf_p1       <= '0;
      count_p1     <= '0;
      skip_pend_p1 <= flush_skip;
      err_p1       <= 1'b0;
    end else begin
      buf_p1   <= buf_next;
      count_p1 <= count_next;
      if (push)
        skip_pend_p1 <= 2'd0;
      err_p1   <= consume & ~cons_legal;
    end
  end

  assign win_data  = buf_p1[39:0];
  assign win_count = count_p1;
  assign err       = err_p1;
endmodule
